// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory access sequencer
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_R,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // lsb takes priority if both size bits are set
  function automatic size_e decode_size(input logic lsb, input logic lsh);
    if (lsb) return SZ_BYTE;
    if (lsh) return SZ_HALF;
    return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input size_e size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - valid/grant data-memory bus between sequencer and memory
interface dmem_access_ctrl_if;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_gnt;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  modport master (
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
    input  i_bus_gnt, i_bus_rvalid, i_bus_rdata
  );

  modport slave (
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
    output i_bus_gnt, i_bus_rvalid, i_bus_rdata
  );
endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - lane select and sign/zero extension of a read word
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  size_e       i_size,
  input  logic        i_signext,
  output logic [31:0] o_data
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = i_rdata[{i_addr, 3'b000} +: 8];
    lane_h = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signext & lane_b[7]}}, lane_b};
      SZ_HALF: o_data = {{16{i_signext & lane_h[15]}}, lane_h};
      default: o_data = i_rdata;
    endcase
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store sequencer for a multi-cycle data bus
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_mem_mem2reg,
  input  logic                  i_mem_wmem,
  input  logic                  i_mem_lsb,
  input  logic                  i_mem_lsh,
  input  logic                  i_mem_loadsignext,
  input  logic [3:0]            i_data_be,
  input  logic [31:0]           i_mem_addr,
  input  logic [31:0]           i_mem_wdata,
  output logic                  o_stall,
  output logic                  o_load_valid,
  output logic [31:0]           o_load_data,
  output logic                  o_misalign,
  output logic                  o_timeout,
  dmem_access_ctrl_if.master    bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d, ld_q, ld_d, sext_q, sext_d;
  size_e         size_q, size_d;
  logic [1:0]    lo_q, lo_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [3:0]    be_q, be_d;
  logic          load_valid_q, load_valid_d, misalign_q, misalign_d, timeout_q, timeout_d;
  logic          access, expired;
  size_e         in_size;
  logic [31:0]   aligned;

  assign access  = i_mem_mem2reg | i_mem_wmem;
  assign in_size = decode_size(i_mem_lsb, i_mem_lsh);
  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  load_align u_align (
    .i_rdata   (bus.i_bus_rdata),
    .i_addr    (lo_q),
    .i_size    (size_q),
    .i_signext (sext_q),
    .o_data    (aligned)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    ld_d         = ld_q;
    sext_d       = sext_q;
    size_d       = size_q;
    lo_d         = lo_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          ld_d = ~i_mem_wmem;
          if (is_misaligned(in_size, i_mem_addr[1:0])) begin
            state_d      = S_DONE;
            misalign_d   = 1'b1;
            load_valid_d = ~i_mem_wmem;
            load_data_d  = '0;
          end else begin
            state_d = S_REQ;
            cnt_d   = '0;
            we_d    = i_mem_wmem;
            addr_d  = {i_mem_addr[31:2], 2'b00};
            lo_d    = i_mem_addr[1:0];
            size_d  = in_size;
            sext_d  = i_mem_loadsignext;
            be_d    = (in_size == SZ_WORD) ? 4'b1111 : i_data_be;
            wdata_d = store_lanes(in_size, i_mem_wdata);
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.i_bus_gnt) begin
          state_d = ld_q ? S_WAIT_R : S_DONE;
        end else if (expired) begin
          state_d      = S_DONE;
          timeout_d    = 1'b1;
          load_valid_d = ld_q;
          if (ld_q) load_data_d = '0;
        end
      end
      S_WAIT_R: begin
        cnt_d = cnt_q + CW'(1);
        // a response in the expiry cycle still completes normally
        if (bus.i_bus_rvalid) begin
          state_d      = S_DONE;
          load_valid_d = 1'b1;
          load_data_d  = aligned;
        end else if (expired) begin
          state_d      = S_DONE;
          timeout_d    = 1'b1;
          load_valid_d = 1'b1;
          load_data_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      ld_q         <= 1'b0;
      sext_q       <= 1'b0;
      size_q       <= SZ_WORD;
      lo_q         <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= 4'b0000;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      ld_q         <= ld_d;
      sext_q       <= sext_d;
      size_q       <= size_d;
      lo_q         <= lo_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_stall         = access & (state_q != S_DONE) & ~i_reset;
  assign o_load_valid    = load_valid_q;
  assign o_load_data     = load_data_q;
  assign o_misalign      = misalign_q;
  assign o_timeout       = timeout_q;
  assign bus.o_bus_req   = req_q;
  assign bus.o_bus_we    = we_q;
  assign bus.o_bus_addr  = addr_q;
  assign bus.o_bus_wdata = wdata_q;
  assign bus.o_bus_be    = be_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for the data-memory access sequencer
module tb_dmem_access_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mem2reg, wmem, lsb, lsh, sext, sel, gnt, rvalid;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  logic stall_a, lv_a, mis_a, to_a, stall_b, lv_b, mis_b, to_b;
  logic [31:0] ld_a, ld_b;

  dmem_access_ctrl_if bus_a ();
  dmem_access_ctrl_if bus_b ();
  assign bus_a.i_bus_gnt    = gnt;
  assign bus_a.i_bus_rvalid = rvalid;
  assign bus_a.i_bus_rdata  = rdata;
  assign bus_b.i_bus_gnt    = gnt;
  assign bus_b.i_bus_rvalid = rvalid;
  assign bus_b.i_bus_rdata  = rdata;

  dmem_access_ctrl dut_a (
    .i_clk(clk), .i_reset(rst), .i_mem_mem2reg(mem2reg & ~sel), .i_mem_wmem(wmem & ~sel),
    .i_mem_lsb(lsb), .i_mem_lsh(lsh), .i_mem_loadsignext(sext), .i_data_be(be),
    .i_mem_addr(addr), .i_mem_wdata(wdata), .o_stall(stall_a), .o_load_valid(lv_a),
    .o_load_data(ld_a), .o_misalign(mis_a), .o_timeout(to_a), .bus(bus_a)
  );

  dmem_access_ctrl #(.TIMEOUT(4)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_mem_mem2reg(mem2reg & sel), .i_mem_wmem(wmem & sel),
    .i_mem_lsb(lsb), .i_mem_lsh(lsh), .i_mem_loadsignext(sext), .i_data_be(be),
    .i_mem_addr(addr), .i_mem_wdata(wdata), .o_stall(stall_b), .o_load_valid(lv_b),
    .o_load_data(ld_b), .o_misalign(mis_b), .o_timeout(to_b), .bus(bus_b)
  );

  wire        acc_m   = mem2reg | wmem;
  wire        stall_m = sel ? stall_b : stall_a;
  wire        lv_m    = sel ? lv_b : lv_a;
  wire        mis_m   = sel ? mis_b : mis_a;
  wire        to_m    = sel ? to_b : to_a;
  wire [31:0] ld_m    = sel ? ld_b : ld_a;
  wire        req_m   = sel ? bus_b.o_bus_req : bus_a.o_bus_req;
  wire        we_m    = sel ? bus_b.o_bus_we : bus_a.o_bus_we;
  wire [31:0] addr_m  = sel ? bus_b.o_bus_addr : bus_a.o_bus_addr;
  wire [31:0] wd_m    = sel ? bus_b.o_bus_wdata : bus_a.o_bus_wdata;
  wire [3:0]  be_m    = sel ? bus_b.o_bus_be : bus_a.o_bus_be;

  typedef struct {
    logic lv; logic chk_data; logic [31:0] data; logic mis; logic to; int stalls;
  } rsp_t;
  typedef struct {
    logic we; logic [31:0] addr; logic chk_w; logic [31:0] wdata; logic [3:0] be;
  } bus_t;

  rsp_t rq[$];
  bus_t bq[$];
  rsp_t mon_e;
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_rsp(input logic lv, input logic cd, input logic [31:0] d,
                         input logic mis, input logic to, input int st);
    rsp_t r;
    r.lv = lv; r.chk_data = cd; r.data = d; r.mis = mis; r.to = to; r.stalls = st;
    rq.push_back(r);
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic cw,
                         input logic [31:0] wd, input logic [3:0] b);
    bus_t t;
    t.we = we; t.addr = a; t.chk_w = cw; t.wdata = wd; t.be = b;
    bq.push_back(t);
  endtask

  // monitor: bus fields every request cycle, response and stall count at completion
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0;
    end else begin
      if (req_m) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_req: unexpected request at 0x%08h, required none", addr_m);
        end else begin
          chk("bus_we", we_m, bq[0].we);
          chk("bus_addr", addr_m, bq[0].addr);
          if (bq[0].chk_w) begin
            chk("bus_wdata", wd_m, bq[0].wdata);
            chk("bus_be", be_m, bq[0].be);
          end
          if (gnt) void'(bq.pop_front());
        end
      end
      if (acc_m && stall_m) begin
        stall_cnt++;
      end else if (acc_m) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL done: unexpected completion, required none");
        end else begin
          mon_e = rq.pop_front();
          chk("load_valid", lv_m, mon_e.lv);
          chk("misalign", mis_m, mon_e.mis);
          chk("timeout", to_m, mon_e.to);
          chk("stall_cycles", stall_cnt, mon_e.stalls);
          if (mon_e.chk_data) chk("load_data", ld_m, mon_e.data);
        end
        stall_cnt = 0;
      end else if (lv_m || mis_m || to_m) begin
        checks++; errors++;
        $display("FAIL pulse: lv=%0b mis=%0b to=%0b outside completion, required 0", lv_m, mis_m, to_m);
      end
    end
  end

  // drive one access; grant on REQ cycle gw, rvalid on WAIT_R cycle rw (-1 = never)
  task automatic run(input logic ld, input logic st, input logic b, input logic h, input logic sx,
                     input logic [3:0] ben, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int gw, input int rw);
    int rc = 0;
    int wc = 0;
    bit wt = 0;
    bit done = 0;
    mem2reg = ld; wmem = st; lsb = b; lsh = h; sext = sx; be = ben; addr = a; wdata = wd; rdata = rd;
    for (int c = 0; c < 40 && !done; c++) begin
      gnt = 1'b0; rvalid = 1'b0;
      if (req_m) begin
        if (rc == gw) begin gnt = 1'b1; wt = ld & ~st; end
        rc++;
      end else if (wt) begin
        if (wc == rw) rvalid = 1'b1;
        wc++;
      end
      @(posedge clk); #1;
      if (!stall_m) done = 1;
    end
    gnt = 1'b0; rvalid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL run_bound: access at 0x%08h still stalled after 40 cycles, required completion", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    mem2reg = 1'b0; wmem = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_a();
    chk("rst_stall", stall_a, 0);
    chk("rst_req", bus_a.o_bus_req, 0);
    chk("rst_we", bus_a.o_bus_we, 0);
    chk("rst_addr", bus_a.o_bus_addr, 0);
    chk("rst_wdata", bus_a.o_bus_wdata, 0);
    chk("rst_be", bus_a.o_bus_be, 0);
    chk("rst_load_valid", lv_a, 0);
    chk("rst_load_data", ld_a, 0);
    chk("rst_misalign", mis_a, 0);
    chk("rst_timeout", to_a, 0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; mem2reg = 1'b1; wmem = 1'b0; lsb = 1'b0; lsh = 1'b0; sext = 1'b0;
    be = 4'h0; addr = 32'h0; wdata = 32'h0; rdata = 32'h0; gnt = 1'b0; rvalid = 1'b0;
    #1;
    chk_reset_a();
    chk("rst_req_b", bus_b.o_bus_req, 0);
    mem2reg = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // loads, back to back
    exp_bus(0, 32'h100, 0, 0, 0); exp_rsp(1, 1, 32'hDEADBEEF, 0, 0, 3);
    run(1, 0, 0, 0, 0, 4'hF, 32'h100, 0, 32'hDEADBEEF, 0, 0);
    exp_bus(0, 32'h100, 0, 0, 0); exp_rsp(1, 1, 32'hFFFFFF80, 0, 0, 3);
    run(1, 0, 1, 0, 1, 4'h8, 32'h103, 0, 32'h80FFFF7F, 0, 0);
    exp_bus(0, 32'h100, 0, 0, 0); exp_rsp(1, 1, 32'h000080FF, 0, 0, 3);
    run(1, 0, 0, 1, 0, 4'hC, 32'h102, 0, 32'h80FFFF7F, 0, 0);
    exp_bus(0, 32'h100, 0, 0, 0); exp_rsp(1, 1, 32'hFFFFFF7F, 0, 0, 4);
    run(1, 0, 0, 1, 1, 4'h3, 32'h100, 0, 32'h80FFFF7F, 0, 1);

    // stores
    exp_bus(1, 32'h200, 1, 32'h12121212, 4'b0010); exp_rsp(0, 0, 0, 0, 0, 7);
    run(0, 1, 1, 0, 0, 4'b0010, 32'h201, 32'h00000012, 0, 5, -1);
    exp_bus(1, 32'h200, 1, 32'hABCDABCD, 4'b1100); exp_rsp(0, 0, 0, 0, 0, 2);
    run(0, 1, 0, 1, 0, 4'b1100, 32'h202, 32'hFFFFABCD, 0, 0, -1);
    exp_bus(1, 32'h204, 1, 32'h12345678, 4'b1111); exp_rsp(0, 0, 0, 0, 0, 2);
    run(0, 1, 0, 0, 0, 4'b0011, 32'h204, 32'h12345678, 0, 0, -1);

    // misaligned accesses, then store-wins and an odd byte load
    exp_rsp(1, 1, 32'h0, 1, 0, 1);
    run(1, 0, 0, 0, 0, 4'hF, 32'h102, 0, 0, -1, -1);
    exp_rsp(0, 0, 0, 1, 0, 1);
    run(0, 1, 0, 1, 0, 4'b1100, 32'h203, 32'h5555, 0, -1, -1);
    exp_bus(1, 32'h208, 1, 32'hA5A55A5A, 4'hF); exp_rsp(0, 0, 0, 0, 0, 2);
    run(1, 1, 0, 0, 0, 4'hF, 32'h208, 32'hA5A55A5A, 0, 0, -1);
    exp_bus(0, 32'h100, 0, 0, 0); exp_rsp(1, 1, 32'h000000A5, 0, 0, 3);
    run(1, 0, 1, 0, 0, 4'h2, 32'h101, 0, 32'h1234A5C3, 0, 0);
    idle();

    // timeout boundaries on the TIMEOUT=4 instance
    sel = 1'b1;
    exp_bus(0, 32'h10, 0, 0, 0); exp_rsp(1, 1, 32'h0, 0, 1, 5);
    run(1, 0, 0, 0, 0, 4'hF, 32'h10, 0, 32'h77777777, -1, -1);
    void'(bq.pop_front());
    exp_bus(0, 32'h14, 0, 0, 0); exp_rsp(1, 1, 32'hCAFEF00D, 0, 0, 5);
    run(1, 0, 0, 0, 0, 4'hF, 32'h14, 0, 32'hCAFEF00D, 0, 2);
    exp_bus(0, 32'h18, 0, 0, 0); exp_rsp(1, 1, 32'h0, 0, 1, 5);
    run(1, 0, 0, 0, 0, 4'hF, 32'h18, 0, 32'h66666666, 0, 3);
    exp_bus(1, 32'h1C, 1, 32'h0BADC0DE, 4'hF); exp_rsp(0, 0, 0, 0, 0, 5);
    run(0, 1, 0, 0, 0, 4'hF, 32'h1C, 32'h0BADC0DE, 0, 3, -1);
    exp_bus(1, 32'h20, 1, 32'h00000001, 4'hF); exp_rsp(0, 0, 0, 0, 1, 5);
    run(0, 1, 0, 0, 0, 4'hF, 32'h20, 32'h00000001, 0, -1, -1);
    void'(bq.pop_front());
    idle();
    sel = 1'b0;

    // reset during WAIT_R, late response afterwards must be dropped
    exp_bus(0, 32'h300, 0, 0, 0);
    mem2reg = 1'b1; lsb = 1'b0; lsh = 1'b0; addr = 32'h300; be = 4'hF;
    @(posedge clk); #1;
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_a();
    mem2reg = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'h55;
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("late_rsp_valid", lv_a, 0);
    chk("late_rsp_data", ld_a, 0);
    exp_bus(0, 32'h104, 0, 0, 0); exp_rsp(1, 1, 32'h11223344, 0, 0, 3);
    run(1, 0, 0, 0, 0, 4'hF, 32'h104, 0, 32'h11223344, 0, 0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rsp_queue_left", rq.size(), 0);
    chk("bus_queue_left", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
